// File: rtl/layer_out_serializer.sv
// layer_out_serializer
// Captures the parallel outputs of one neuron layer in a single cycle and
// replays them one value per cycle, neuron 0 first, as the input stream of the
// next layer.
// Optional argmax tracking is built when the macro SER_ARGMAX_EN is defined.
// Without SER_ARGMAX_EN, max_idx and max_valid are tied to 0.
module layer_out_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATAWIDTH   = 16,
    localparam int IDXW       = $clog2(NUM_NEURONS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_NEURONS*DATAWIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]           neuron_valid,
    output logic [DATAWIDTH-1:0]             data_out,
    output logic                             data_valid,
    output logic                             busy,
    output logic                             overrun,
    output logic                             misalign,
    output logic [IDXW-1:0]                  max_idx,
    output logic                             max_valid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [IDXW-1:0]        LAST_IDX = IDXW'(NUM_NEURONS - 1);
    localparam logic [NUM_NEURONS-1:0] ALL_ONES = '1;

    logic [0:0]           state_reg;
    logic [0:0]           state_next;
    logic [IDXW-1:0]      cnt_reg;
    logic [IDXW-1:0]      cnt_next;
    logic [DATAWIDTH-1:0] data_out_reg;
    logic                 data_valid_reg;
    logic                 overrun_reg;
    logic                 misalign_reg;

    // Capture buffer: one word per source neuron.
    logic [DATAWIDTH-1:0] buffer_reg [NUM_NEURONS];
    logic [DATAWIDTH-1:0] word_in    [NUM_NEURONS];
    logic [DATAWIDTH-1:0] beat_word;

    logic all_valid;
    logic any_valid;
    logic last_beat;
    logic busy_int;
    logic capture;

    // Unpack the flat neuron bus into per-neuron words.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_unpack
            assign word_in[gi] = neuron_out[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    // Input qualification: a vector is only accepted when every neuron is
    // valid and the serializer is either idle or on its final beat.
    always_comb begin
        all_valid = (neuron_valid == ALL_ONES);
        any_valid = |neuron_valid;
        last_beat = (state_reg == ST_SEND) && (cnt_reg == LAST_IDX);
        busy_int  = (state_reg == ST_SEND) && (cnt_reg != LAST_IDX);
        capture   = all_valid && !busy_int;
        beat_word = buffer_reg[cnt_reg];
    end

    // Buffer load; contents need no reset because nothing is replayed until
    // a capture has overwritten every word.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                buffer_reg[i] <= word_in[i];
            end
        end
    end

    // Next-state logic: IDLE -> SEND on capture; SEND walks cnt up to the
    // last neuron, then either reloads back-to-back or drops to IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (capture) begin
                    state_next = ST_SEND;
                    cnt_next   = '0;
                end
            end
            ST_SEND: begin
                if (last_beat) begin
                    cnt_next = '0;
                    if (!capture) begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + IDXW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            data_valid_reg <= (state_reg == ST_SEND);
            if (state_reg == ST_SEND) begin
                data_out_reg <= beat_word;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg  <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            if (all_valid && busy_int) begin
                overrun_reg <= 1'b1;
            end
            if (any_valid && !all_valid) begin
                misalign_reg <= 1'b1;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign busy       = busy_int;
    assign overrun    = overrun_reg;
    assign misalign   = misalign_reg;

`ifdef SER_ARGMAX_EN
    logic signed [DATAWIDTH-1:0] run_max_reg;
    logic [IDXW-1:0]             run_idx_reg;
    logic [IDXW-1:0]             max_idx_reg;
    logic                        max_valid_reg;
    logic                        done_reg;
    logic                        beat_greater;

    // Strictly greater only, so ties keep the earliest (lowest) index.
    always_comb begin
        beat_greater = $signed(beat_word) > run_max_reg;
    end

    // Running max follows the beats; the result is published one cycle
    // after the last beat so a back-to-back stream can restart tracking
    // on its beat 0 while the previous result is still being latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_reg   <= '0;
            run_idx_reg   <= '0;
            max_idx_reg   <= '0;
            max_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            max_valid_reg <= done_reg;
            if (done_reg) begin
                max_idx_reg <= run_idx_reg;
            end
            done_reg <= last_beat;
            if (state_reg == ST_SEND) begin
                if ((cnt_reg == '0) || beat_greater) begin
                    run_max_reg <= $signed(beat_word);
                    run_idx_reg <= cnt_reg;
                end
            end
        end
    end

    assign max_idx   = max_idx_reg;
    assign max_valid = max_valid_reg;
`else
    assign max_idx   = '0;
    assign max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Testbench for layer_out_serializer: queue-based reference model with a
// per-cycle compare, directed scenarios with literal expectations, random
// traffic, and a separate 30-neuron instance for the long-stream case.
module tb_layer_out_serializer;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IW  = $clog2(N);
    localparam int N2  = 30;
    localparam int IW2 = $clog2(N2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0] neuron_out   = '0;
    logic [N-1:0]   neuron_valid = '0;
    logic [W-1:0]   data_out;
    logic           data_valid, busy, overrun, misalign, max_valid;
    logic [IW-1:0]  max_idx;

    logic [N2*W-1:0] out30 = '0;
    logic [N2-1:0]   nv30  = '0;
    logic [W-1:0]    dout30;
    logic            dv30, busy30, ovr30, mis30, mv30;
    logic [IW2-1:0]  midx30;

    layer_out_serializer #(.NUM_NEURONS(N), .DATAWIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .neuron_out(neuron_out), .neuron_valid(neuron_valid),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .overrun(overrun),
        .misalign(misalign), .max_idx(max_idx), .max_valid(max_valid));

    layer_out_serializer #(.NUM_NEURONS(N2), .DATAWIDTH(W)) u_dut30 (
        .clk(clk), .rst_n(rst_n), .neuron_out(out30), .neuron_valid(nv30),
        .data_out(dout30), .data_valid(dv30), .busy(busy30), .overrun(ovr30),
        .misalign(mis30), .max_idx(midx30), .max_valid(mv30));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending beats of the current (and possibly next) stream; each carries
    // the argmax of the vector it came from so the result is known on the
    // last beat.
    typedef struct {
        logic [W-1:0] v;
        bit           last;
        int           midx;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] m_dout = '0;
    bit           m_dv = 0, m_ovr = 0, m_mis = 0, m_mv = 0;
    int           m_midx = 0;
    bit           pend = 0;
    int           pend_idx = 0;

    always @(posedge clk or negedge rst_n) begin
        bit full;
        bit busy_m;
        beat_t b;
        beat_t nb;
        int best;
        logic signed [W-1:0] bv;
        if (!rst_n) begin
            q.delete();
            m_dout = '0; m_dv = 0; m_ovr = 0; m_mis = 0; m_mv = 0; m_midx = 0;
            pend = 0; pend_idx = 0;
        end else begin
            full   = (neuron_valid == '1);
            busy_m = (q.size() > 1);
`ifdef SER_ARGMAX_EN
            m_mv = pend;
            if (pend) m_midx = pend_idx;
`endif
            pend = 0;
            if (q.size() > 0) begin
                b = q.pop_front();
                m_dout = b.v;
                m_dv   = 1;
                if (b.last) begin
                    pend = 1;
                    pend_idx = b.midx;
                end
            end else begin
                m_dv = 0;
            end
            if (full && busy_m) m_ovr = 1;
            if (neuron_valid != '0 && !full) m_mis = 1;
            if (full && !busy_m) begin
                best = 0;
                bv   = neuron_out[0 +: W];
                for (int i = 1; i < N; i++) begin
                    if ($signed(neuron_out[i*W +: W]) > bv) begin
                        bv = neuron_out[i*W +: W];
                        best = i;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    nb.v = neuron_out[i*W +: W];
                    nb.last = (i == N - 1);
                    nb.midx = best;
                    q.push_back(nb);
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("data_out", 32'(data_out), 32'(m_dout));
        check("busy", 32'(busy), 32'(q.size() > 1));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("misalign", 32'(misalign), 32'(m_mis));
        check("max_valid", 32'(max_valid), 32'(m_mv));
        check("max_idx", 32'(max_idx), 32'(m_midx));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_vec(input logic [N*W-1:0] vals, input logic [N-1:0] nv);
        @(posedge clk); #1;
        neuron_out   = vals;
        neuron_valid = nv;
        @(posedge clk); #1;
        neuron_valid = '0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 3))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    int found;
    int beats;
    logic [W-1:0] got30 [N2];

    initial begin
        // Reset state
        #12;
        check("rst_dv", 32'(data_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_mis", 32'(misalign), 0);
        check("rst_mv", 32'(max_valid), 0);
        @(negedge clk); rst_n = 1'b1;

        // 1: basic stream with literal expectations
        drive_vec({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF);
        @(negedge clk);
        check("t1_gap_dv", 32'(data_valid), 0);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check("t1_dv", 32'(data_valid), 1);
            check("t1_data", 32'(data_out), 32'(k + 1));
        end
        @(negedge clk);
        check("t1_end_dv", 32'(data_valid), 0);
        check("t1_end_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);

        // 2: drop while busy, then back-to-back on the last beat
        drive_vec({16'd14, 16'd13, 16'd12, 16'd11}, 4'hF);
        drive_vec({16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, 4'hF);
        drive_vec({16'd24, 16'd23, 16'd22, 16'd21}, 4'hF);
        repeat (2 * N + 4) @(posedge clk);
        @(negedge clk);
        check("t2_overrun", 32'(overrun), 1);

        // 5: argmax with signed compare and a tie
        drive_vec({16'h7FFF, 16'h8000, 16'h7FFF, 16'h0001}, 4'hF);
        found = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (max_valid) begin
                found++;
`ifdef SER_ARGMAX_EN
                check("t5_max_idx", 32'(max_idx), 1);
`endif
            end
        end
`ifdef SER_ARGMAX_EN
        check("t5_pulses", 32'(found), 1);
`else
        check("t5_no_pulse", 32'(found), 0);
`endif

        // 3: misaligned valid, then a normal stream
        drive_vec({16'd1, 16'd2, 16'd3, 16'd4}, 4'b0101);
        @(negedge clk);
        check("t3_misalign", 32'(misalign), 1);
        check("t3_no_dv", 32'(data_valid), 0);
        drive_vec({16'd9, 16'd8, 16'd7, 16'd6}, 4'hF);
        repeat (N + 3) @(posedge clk);

        // 4: asynchronous reset after beat 1
        drive_vec({16'd40, 16'd30, 16'd20, 16'd10}, 4'hF);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("t4_beat1", 32'(data_out), 20);
        check("t4_pre_ovr", 32'(overrun), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_dv", 32'(data_valid), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_ovr", 32'(overrun), 0);
        check("t4_mis", 32'(misalign), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        found = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (data_valid) found++;
        end
        check("t4_no_beats", 32'(found), 0);

        // Random traffic, including occasional async resets
        for (int cyc = 0; cyc < 800; cyc++) begin
            int r;
            @(posedge clk); #1;
            r = $urandom_range(0, 99);
            if (r < 45) begin
                neuron_valid = '0;
            end else if (r < 85) begin
                for (int i = 0; i < N; i++) neuron_out[i*W +: W] = pick();
                neuron_valid = '1;
            end else begin
                neuron_valid = N'($urandom_range(1, 14));
            end
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1 neuron_valid = '0;
        repeat (N + 4) @(posedge clk);

        // 6: 30-neuron instance streams exactly 30 beats
        @(posedge clk); #1;
        for (int i = 0; i < N2; i++) out30[i*W +: W] = W'(i * 7 + 3);
        nv30 = '1;
        @(posedge clk); #1 nv30 = '0;
        beats = 0;
        for (int k = 0; k < N2 + 10; k++) begin
            @(negedge clk);
            if (dv30) begin
                if (beats < N2) got30[beats] = dout30;
                beats++;
            end
        end
        check("t6_beats", 32'(beats), 32'(N2));
        for (int i = 0; i < N2; i++) check("t6_data", 32'(got30[i]), 32'(i * 7 + 3));
        check("t6_busy", 32'(busy30), 0);
        check("t6_ovr", 32'(ovr30), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
